ds_tx_arbiter: RTL

Packet-level round-robin arbiter that shares one horizontal NAP data-stream transmit interface among NUM_REQ requester modules. It sits between the requesters, each of which is sender-like and has its own destination column, and the `if_ds_tx` side of a single `nap_horizontal_wrapper`. A grant is locked for a whole packet, so beats from different requesters never interleave on the NoC.

---
 rtl/ds_tx_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ds_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one NAP data-stream transmit port
// among NUM_REQ requesters; the grant is held from first beat to eop.
module ds_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]          req_eop,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic [ADDR_W-1:0]           tx_addr,
  output logic                        tx_sop,
  output logic                        tx_eop,
  output logic                        busy,
  output logic [2:0]                  grant_id,
  output logic [15:0]                 pkt_count
);

  localparam int unsigned GNT_W = 3;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [0:0] {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  logic [GNT_W-1:0]   grant_q, grant_d;
  logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               first_beat_q, first_beat_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

  logic               sel_found;
  logic [GNT_W-1:0]   sel_idx;
  int unsigned        cand;

  logic               g_valid;
  logic [DATA_W-1:0]  g_data;
  logic [ADDR_W-1:0]  g_addr;
  logic               g_eop;
  logic               hs;

  // Round-robin pick: first valid requester scanning upward from rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!sel_found && (cand == j) && req_valid[j]) begin
          sel_found = 1'b1;
          sel_idx   = GNT_W'(j);
        end
      end
    end
  end

  // Granted requester's beat slice.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_addr  = '0;
    g_eop   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GNT_W'(i)) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DATA_W +: DATA_W];
        g_addr  = req_addr[i*ADDR_W +: ADDR_W];
        g_eop   = req_eop[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    first_beat_d = first_beat_q;
    pkt_count_d  = pkt_count_q;
    req_ready    = '0;
    tx_valid     = 1'b0;
    tx_sop       = 1'b0;
    tx_data      = g_data;
    tx_addr      = g_addr;
    tx_eop       = g_eop;
    hs           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d      = sel_idx;
          first_beat_d = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        tx_valid = g_valid;
        tx_sop   = first_beat_q & g_valid;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_q == GNT_W'(i)) & tx_ready;
        end
        hs = g_valid & tx_ready;
        if (hs) first_beat_d = 1'b0;
        if (hs && g_eop) begin
          rr_ptr_d    = (grant_q == GNT_W'(NUM_REQ - 1)) ? '0 : grant_q + GNT_W'(1);
          pkt_count_d = pkt_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      first_beat_q <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      first_beat_q <= first_beat_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign busy      = (state_q == SEND);
  assign grant_id  = busy ? grant_q : '0;
  assign pkt_count = pkt_count_q;

endmodule
